flash_prog: RTL and testbench
=============================

# flash_prog

Program/erase controller for the board's 16-bit parallel NOR flash (AMD command set, word mode). It accepts write transfers on the same internal bus used for flash reads and turns them into unlock/program command sequences. It then polls DQ7 until the operation completes. It drives the flash pins only while a transfer is active, so the bus top-level can multiplex it with the read controller.

## Interface
- WE_CYCLES, 4: clocks we_n stays low, and clocks it stays high, per command write
- READ_CYCLES, 6: clocks oe_n stays low per poll read; d_in is sampled on the last clock
- POLL_MAX, 65535: maximum poll reads per program/erase before an error is declared
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- en  in  1  transfer request
- wr  in  1  1 = program/erase, 0 = status read
- size  in  2  1x = word, 01 = halfword, 00 = byte (erase, see Configuration)
- addr  in  21  byte address
- data_in  in  32  write data, big-endian on the bus
- data_out  out  32  status on reads: bit0 = sticky error, others 0
- wt  out  1  wait; low for exactly one clock = transfer complete
- ce_n, oe_n, we_n  out  1  flash strobes
- rst_n, byte_n  out  1  constant 1
- a  out  20  flash halfword address
- d_out  out  16  flash write data
- d_oe  out  1  1 = drive d_out onto the flash data pins
- d_in  in  16  flash read data

## Operation
- Reset values: wt=1, data_out=0, err=0, ce_n=1, oe_n=1, we_n=1, d_oe=0, a=0, d_out=0.
- Byte lane mapping for flash data:
  - d_out[7:0] = bus[15:8]
  - d_out[15:8] = bus[7:0]
  - The same mapping applies to poll data.
- Word program:
  - First halfword: data_in[31:16] at a = {addr[20:2],0}.
  - Second halfword: data_in[15:0] at a0 = 1.
  - Each halfword is a full command sequence followed by polling.
  - If the first halfword fails, the second is skipped.
- Halfword program: data_in[15:0] at a = {addr[20:2],addr[1]}.
- Program sequence, as (a, d_out) command writes: (0x555,0x00AA), (0x2AA,0x0055), (0x555,0x00A0), (target, data).
- States:
  - IDLE: en=1 and wr=1 go to SETUP. en=1 and wr=0 go to ACK with data_out={31'b0,err}, after which err clears.
  - SETUP: ce_n=0, d_oe=1, a/d_out loaded; lasts 1 clock, then WE_LO.
  - WE_LO: we_n=0 for WE_CYCLES clocks, then WE_HI.
  - WE_HI: we_n=1 for WE_CYCLES clocks. Next state is SETUP for the next step, or POLL after the last step.
  - POLL: d_oe=0, oe_n=0, a=target for READ_CYCLES clocks; d_in is sampled at the last one.
    - Success when the DQ7 bit (mapped lane) equals the written DQ7, or equals 1 for erase.
    - If POLL_MAX reads pass without success: set err and issue one reset command write (any a, 0x00F0), then go to ACK.
    - Between reads, oe_n returns high for 1 clock.
  - ACK: all strobes high, d_oe=0, wt=0 for one clock, then IDLE with wt=1.
- The master must drop en (or present a new transfer) in the clock after wt goes low. If en is still high in IDLE, a new transfer starts.
- Reset during any state returns immediately to reset values. No recovery command is issued, and the flash may be left mid-operation.
- err is sticky. Only a status read or reset clears it.

## Timing
- Command write cost: 1 + 2*WE_CYCLES clocks; 9 with defaults.
- Poll read cost: READ_CYCLES + 1 clocks.
- Halfword program, defaults, first poll succeeds: 4*9 + 7 + 1 (ACK) = 44 clocks from the en sample to wt low.
- Word program, same conditions: 2*(36+7) + 1 = 87 clocks.
- Status read: wt low on the second clock after en is sampled.
- a, d_out and d_oe change only on SETUP entry or POLL entry. They are stable throughout each we_n low or oe_n low window.

## Configuration
- FLASH_ERASE_EN defined:
  - A write with size=00 performs a sector erase for the sector containing addr.
  - Sequence: (0x555,AA), (0x2AA,55), (0x555,80), (0x555,AA), (0x2AA,55), (sector,0x0030), where sector = addr[20:1].
  - Polling succeeds when DQ7=1.
- FLASH_ERASE_EN undefined:
  - A size=00 write performs no flash cycles.
  - It sets err and acknowledges via ACK 2 clocks after en is sampled.

## Test plan
- Halfword write, addr=0x000102, data_in=0x00001234, flash model completes after 2 polls:
  - Four writes appear: 555/00AA, 2AA/0055, 555/00A0, 000081/3412.
  - wt is low for exactly 1 clock.
  - A subsequent status read returns 0.
- Word write, addr=0x000200, data_in=0xAABBCCDD:
  - a=0x00100 gets d_out=0xBBAA.
  - a=0x00101 gets d_out=0xDDCC.
  - One ACK follows the second poll success.
- Model never toggles DQ7, POLL_MAX=4:
  - Exactly 4 polls occur, followed by an F0 write.
  - ACK follows, and the status read returns 1.
  - A second status read returns 0.
- reset asserted during WE_LO of the third command write:
  - Next clock shows we_n=1, ce_n=1, d_oe=0, wt=1.
  - The block is back in IDLE.
- Byte write to addr=0x010000:
  - With FLASH_ERASE_EN: the 6-write erase sequence ends with 08000/0030, then polls until DQ7=1.
  - Without FLASH_ERASE_EN: no strobes, wt low 2 clocks after en, and err=1.

Source files
------------

// File: rtl/flash_prog.sv
// flash_prog: program/erase controller for a 16-bit AMD-command-set NOR flash, with DQ7 completion polling.
// Optional feature macro FLASH_ERASE_EN: size=00 writes become sector erases (otherwise they only flag an error).
module flash_prog #(
    parameter int WE_CYCLES   = 4,
    parameter int READ_CYCLES = 6,
    parameter int POLL_MAX    = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [20:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        wt,
    output logic        ce_n,
    output logic        oe_n,
    output logic        we_n,
    output logic        rst_n,
    output logic        byte_n,
    output logic [19:0] a,
    output logic [15:0] d_out,
    output logic        d_oe,
    input  logic [15:0] d_in,
    output logic [2:0]  state_dbg
);

    // Handshake: a transfer is accepted when en=1 is seen in IDLE; wt drops for exactly
    // one clock when it completes, and the master must drop en (or present a new transfer) next clock.

    localparam int CNT_MAX = (WE_CYCLES > READ_CYCLES) ? WE_CYCLES : READ_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PCNT_W  = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WE_LO, S_WE_HI, S_POLL, S_ACK
    } state_t;

    typedef enum logic [1:0] {
        M_PROG, M_ERASE, M_RESET
    } mode_t;

    state_t             state;
    mode_t              mode;
    logic [2:0]         step;
    logic [CNT_W-1:0]   cnt;
    logic [PCNT_W-1:0]  poll_cnt;
    logic [19:0]        target;
    logic [15:0]        wdata;
    logic [15:0]        wdata2;
    logic               second;
    logic               dq7_s;
    logic               err;
    logic               poll_ok;
    logic               unused_bits;

    assign rst_n       = 1'b1;
    assign byte_n      = 1'b1;
    assign state_dbg   = state;
    assign unused_bits = ^{addr[0], d_in[15:8], d_in[6:0]};

    // Erase completes on DQ7=1; program completes when DQ7 reads back as written.
    assign poll_ok = (mode == M_ERASE) ? dq7_s : (dq7_s == wdata[7]);

    function automatic logic [15:0] swap16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    function automatic logic [2:0] last_step(input mode_t m);
        case (m)
            M_PROG:  return 3'd3;
            M_ERASE: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [19:0] cmd_addr(input mode_t m, input logic [2:0] s, input logic [19:0] t);
        logic [19:0] r;
        r = t;
        if (m == M_PROG || m == M_ERASE) begin
            case (s)
                3'd0, 3'd2: r = 20'h00555;
                3'd1:       r = 20'h002AA;
                3'd3:       r = (m == M_ERASE) ? 20'h00555 : t;
                3'd4:       r = 20'h002AA;
                default:    r = t;
            endcase
        end
        return r;
    endfunction

    function automatic logic [15:0] cmd_data(input mode_t m, input logic [2:0] s, input logic [15:0] w);
        logic [15:0] r;
        r = 16'h00F0;
        if (m == M_PROG) begin
            case (s)
                3'd0:    r = 16'h00AA;
                3'd1:    r = 16'h0055;
                3'd2:    r = 16'h00A0;
                default: r = w;
            endcase
        end else if (m == M_ERASE) begin
            case (s)
                3'd0, 3'd3: r = 16'h00AA;
                3'd1, 3'd4: r = 16'h0055;
                3'd2:       r = 16'h0080;
                default:    r = 16'h0030;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            mode     <= M_PROG;
            step     <= 3'd0;
            cnt      <= '0;
            poll_cnt <= '0;
            target   <= 20'h0;
            wdata    <= 16'h0;
            wdata2   <= 16'h0;
            second   <= 1'b0;
            dq7_s    <= 1'b0;
            err      <= 1'b0;
            data_out <= 32'h0;
            wt       <= 1'b1;
            ce_n     <= 1'b1;
            oe_n     <= 1'b1;
            we_n     <= 1'b1;
            d_oe     <= 1'b0;
            a        <= 20'h0;
            d_out    <= 16'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        if (!wr) begin
                            data_out <= {31'b0, err};
                            err      <= 1'b0;
                            wt       <= 1'b0;
                            state    <= S_ACK;
                        end else if (size == 2'b00) begin
`ifdef FLASH_ERASE_EN
                            mode   <= M_ERASE;
                            step   <= 3'd0;
                            second <= 1'b0;
                            target <= addr[20:1];
                            a      <= cmd_addr(M_ERASE, 3'd0, addr[20:1]);
                            d_out  <= cmd_data(M_ERASE, 3'd0, 16'h0000);
                            ce_n   <= 1'b0;
                            d_oe   <= 1'b1;
                            state  <= S_SETUP;
`else
                            err   <= 1'b1;
                            wt    <= 1'b0;
                            state <= S_ACK;
`endif
                        end else begin
                            mode   <= M_PROG;
                            step   <= 3'd0;
                            second <= size[1];
                            target <= size[1] ? {addr[20:2], 1'b0} : addr[20:1];
                            wdata  <= size[1] ? swap16(data_in[31:16]) : swap16(data_in[15:0]);
                            wdata2 <= swap16(data_in[15:0]);
                            a      <= cmd_addr(M_PROG, 3'd0, 20'h0);
                            d_out  <= cmd_data(M_PROG, 3'd0, 16'h0000);
                            ce_n   <= 1'b0;
                            d_oe   <= 1'b1;
                            state  <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    we_n  <= 1'b0;
                    cnt   <= '0;
                    state <= S_WE_LO;
                end
                S_WE_LO: begin
                    if (cnt == CNT_W'(WE_CYCLES - 1)) begin
                        we_n  <= 1'b1;
                        cnt   <= '0;
                        state <= S_WE_HI;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WE_HI: begin
                    if (cnt == CNT_W'(WE_CYCLES - 1)) begin
                        cnt <= '0;
                        if (step == last_step(mode)) begin
                            if (mode == M_RESET) begin
                                ce_n  <= 1'b1;
                                d_oe  <= 1'b0;
                                wt    <= 1'b0;
                                state <= S_ACK;
                            end else begin
                                d_oe     <= 1'b0;
                                oe_n     <= 1'b0;
                                a        <= target;
                                poll_cnt <= '0;
                                state    <= S_POLL;
                            end
                        end else begin
                            step  <= step + 3'd1;
                            a     <= cmd_addr(mode, step + 3'd1, target);
                            d_out <= cmd_data(mode, step + 3'd1, wdata);
                            state <= S_SETUP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_POLL: begin
                    if (cnt == CNT_W'(READ_CYCLES - 1)) begin
                        dq7_s <= d_in[7];
                        oe_n  <= 1'b1;
                        cnt   <= cnt + CNT_W'(1);
                    end else if (cnt == CNT_W'(READ_CYCLES)) begin
                        cnt <= '0;
                        if (poll_ok) begin
                            if (second) begin
                                second <= 1'b0;
                                target <= {target[19:1], 1'b1};
                                wdata  <= wdata2;
                                step   <= 3'd0;
                                a      <= cmd_addr(M_PROG, 3'd0, 20'h0);
                                d_out  <= cmd_data(M_PROG, 3'd0, 16'h0000);
                                d_oe   <= 1'b1;
                                state  <= S_SETUP;
                            end else begin
                                ce_n  <= 1'b1;
                                wt    <= 1'b0;
                                state <= S_ACK;
                            end
                        end else if (poll_cnt == PCNT_W'(POLL_MAX - 1)) begin
                            // Timed out: flag it and return the flash to read mode.
                            err    <= 1'b1;
                            mode   <= M_RESET;
                            step   <= 3'd0;
                            second <= 1'b0;
                            a      <= cmd_addr(M_RESET, 3'd0, target);
                            d_out  <= cmd_data(M_RESET, 3'd0, 16'h0000);
                            d_oe   <= 1'b1;
                            state  <= S_SETUP;
                        end else begin
                            poll_cnt <= poll_cnt + PCNT_W'(1);
                            oe_n     <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ACK: begin
                    wt    <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_prog.sv
// Bench for flash_prog: a flash pin monitor checks every command write and poll read against an
// expected transaction list built from the command-set rules, with a small DQ7 flash model.
`timescale 1ns/1ps
module tb_flash_prog;

    localparam int WE   = 4;
    localparam int RD   = 6;
    localparam int PMAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [20:0] addr = 21'h0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        wt, ce_n, oe_n, we_n, rst_n, byte_n, d_oe;
    logic [19:0] a;
    logic [15:0] d_out;
    logic [15:0] d_in;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    flash_prog #(.WE_CYCLES(WE), .READ_CYCLES(RD), .POLL_MAX(PMAX)) dut (
        .clk(clk), .reset(reset), .en(en), .wr(wr), .size(size), .addr(addr),
        .data_in(data_in), .data_out(data_out), .wt(wt), .ce_n(ce_n), .oe_n(oe_n),
        .we_n(we_n), .rst_n(rst_n), .byte_n(byte_n), .a(a), .d_out(d_out),
        .d_oe(d_oe), .d_in(d_in), .state_dbg(state_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected flash writes: {address matters, a, d_out}; expected poll addresses.
    logic [36:0] exp_q[$];
    logic [19:0] poll_q[$];

    // Flash model: reads after a command write return DQ7 inverted for busy_reads reads.
    int          reads_cnt = 0;
    int          busy_reads = 0;
    bit          erase_op = 1'b0;
    logic [15:0] last_wd = 16'h0;

    assign d_in = (reads_cnt < busy_reads) ? (erase_op ? 16'h0000 : (last_wd ^ 16'h0080))
                                           : (erase_op ? 16'hFFFF : last_wd);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Pin monitor: compares every write and poll window against the expected lists.
    logic        prev_we = 1'b1;
    logic        prev_oe = 1'b1;
    logic [19:0] win_a = 20'h0;
    logic [15:0] win_d = 16'h0;
    logic [19:0] win_pa = 20'h0;
    int          writes_seen = 0;
    int          polls_seen = 0;

    always @(negedge clk) begin
        logic [36:0] e;
        if (!reset) begin
            if (prev_we && !we_n) begin
                writes_seen++;
                check("write_ce_n", ce_n, 1'b0);
                check("write_d_oe", d_oe, 1'b1);
                check("rst_n_byte_n", {rst_n, byte_n}, 2'b11);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got a=0x%0h d=0x%0h, required no write", a, d_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e[36]) check("write_a", a, e[35:16]);
                    check("write_d", d_out, e[15:0]);
                end
                win_a   = a;
                win_d   = d_out;
                last_wd = d_out;
            end else if (!prev_we && !we_n) begin
                check("we_window_stable", {a, d_out}, {win_a, win_d});
            end
            if (!prev_we && we_n) reads_cnt = 0;
            if (prev_oe && !oe_n) begin
                polls_seen++;
                check("poll_ce_n", ce_n, 1'b0);
                check("poll_d_oe", d_oe, 1'b0);
                if (poll_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_poll: got poll at a=0x%0h, required no poll", a);
                end else begin
                    check("poll_a", a, poll_q.pop_front());
                end
                win_pa = a;
            end else if (!prev_oe && !oe_n) begin
                check("oe_window_stable", a, win_pa);
            end
            if (!prev_oe && oe_n) reads_cnt++;
        end
        prev_we = we_n;
        prev_oe = oe_n;
    end

    task automatic exp_write(input logic care, input logic [19:0] ea, input logic [15:0] ed);
        exp_q.push_back({care, ea, ed});
    endtask

    task automatic exp_polls(input logic [19:0] ta, input int n);
        for (int i = 0; i < n; i++) poll_q.push_back(ta);
    endtask

    // One halfword program: unlock, program command, data with lanes swapped, then n polls.
    task automatic exp_prog_half(input logic [19:0] ta, input logic [15:0] bus_hw, input int npolls);
        exp_write(1'b1, 20'h00555, 16'h00AA);
        exp_write(1'b1, 20'h002AA, 16'h0055);
        exp_write(1'b1, 20'h00555, 16'h00A0);
        exp_write(1'b1, ta, {bus_hw[7:0], bus_hw[15:8]});
        exp_polls(ta, npolls);
    endtask

    function automatic int cmd_clocks(input int n_writes, input int n_polls);
        return n_writes * (1 + 2 * WE) + n_polls * (RD + 1);
    endfunction

    // k counts clocks after the en-sampling edge; the wt-low clock is k (status read: k=1).
    task automatic run_xfer(input string name, input logic w, input logic [1:0] sz,
                            input logic [20:0] ad, input logic [31:0] dt, input int exp_clk,
                            input bit chk_do, input logic [31:0] exp_do);
        int k;
        bit seen;
        @(negedge clk);
        en = 1'b1; wr = w; size = sz; addr = ad; data_in = dt;
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            k++;
            if (wt == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no wt pulse in 2000 clocks, required one", name);
        end else begin
            check({name, "_latency"}, k, exp_clk);
            if (chk_do) check({name, "_data_out"}, data_out, exp_do);
        end
        en = 1'b0; wr = 1'b0;
        @(negedge clk);
        #1;
        check({name, "_wt_width"}, wt, 1'b1);
        check({name, "_writes_left"}, exp_q.size(), 0);
        check({name, "_polls_left"}, poll_q.size(), 0);
    endtask

    initial begin
        int base;
        bit found;

        repeat (3) @(negedge clk);
        check("rst_wt", wt, 1'b1);
        check("rst_strobes", {ce_n, oe_n, we_n, d_oe}, 4'b1110);
        check("rst_a_d", {a, d_out}, 36'h0);
        check("rst_data_out", data_out, 32'h0);
        reset = 1'b0;

        // Halfword, second poll succeeds: hand-written command stream, 44 + 7 clocks.
        busy_reads = 1;
        exp_write(1'b1, 20'h00555, 16'h00AA);
        exp_write(1'b1, 20'h002AA, 16'h0055);
        exp_write(1'b1, 20'h00555, 16'h00A0);
        exp_write(1'b1, 20'h00081, 16'h3412);
        exp_polls(20'h00081, 2);
        run_xfer("half", 1'b1, 2'b01, 21'h000102, 32'h00001234, 51, 1'b0, 32'h0);
        run_xfer("status_a", 1'b0, 2'b00, 21'h0, 32'h0, 1, 1'b1, 32'h0);

        // Word, first poll succeeds on each half.
        busy_reads = 0;
        exp_write(1'b1, 20'h00555, 16'h00AA);
        exp_write(1'b1, 20'h002AA, 16'h0055);
        exp_write(1'b1, 20'h00555, 16'h00A0);
        exp_write(1'b1, 20'h00100, 16'hBBAA);
        exp_polls(20'h00100, 1);
        exp_prog_half(20'h00101, 16'hCCDD, 1);
        run_xfer("word", 1'b1, 2'b10, 21'h000200, 32'hAABBCCDD, 87, 1'b0, 32'h0);
        run_xfer("status_b", 1'b0, 2'b00, 21'h0, 32'h0, 1, 1'b1, 32'h0);

        // Halfword with busy DQ7 shifted in model: 3 polls, computed from the timing rules.
        busy_reads = 2;
        exp_prog_half(20'h12345, 16'hC3A5, 3);
        run_xfer("half_busy", 1'b1, 2'b01, 21'h02468A, 32'hFFFFC3A5, cmd_clocks(4, 3) + 1, 1'b0, 32'h0);

        // DQ7 never completes: PMAX polls, one F0 reset write, sticky error.
        busy_reads = 1000;
        exp_prog_half(20'h00008, 16'h0080, PMAX);
        exp_write(1'b0, 20'h0, 16'h00F0);
        run_xfer("timeout", 1'b1, 2'b01, 21'h000010, 32'h00000080, 74, 1'b0, 32'h0);
        run_xfer("status_err", 1'b0, 2'b00, 21'h0, 32'h0, 1, 1'b1, 32'h1);
        run_xfer("status_clr", 1'b0, 2'b00, 21'h0, 32'h0, 1, 1'b1, 32'h0);

        // Word where the first half times out: second half is skipped.
        exp_prog_half(20'h00200, 16'h1111, PMAX);
        exp_write(1'b0, 20'h0, 16'h00F0);
        run_xfer("word_fail", 1'b1, 2'b10, 21'h000400, 32'h11112222, cmd_clocks(5, PMAX) + 1, 1'b0, 32'h0);
        run_xfer("status_err2", 1'b0, 2'b00, 21'h0, 32'h0, 1, 1'b1, 32'h1);

        // Reset in the middle of the third command write's we_n-low window.
        busy_reads = 0;
        exp_prog_half(20'h00020, 16'h5678, 1);
        base = writes_seen;
        @(negedge clk);
        en = 1'b1; wr = 1'b1; size = 2'b01; addr = 21'h000040; data_in = 32'h00005678;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (writes_seen == base + 3) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL reset_wait: got %0d writes, required 3", writes_seen - base);
        end
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0; wr = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_we_n", we_n, 1'b1);
        check("midrst_ce_n", ce_n, 1'b1);
        check("midrst_d_oe", d_oe, 1'b0);
        check("midrst_wt", wt, 1'b1);
        check("midrst_a_d", {a, d_out}, 36'h0);
        reset = 1'b0;
        exp_q.delete();
        poll_q.delete();
        run_xfer("status_after_rst", 1'b0, 2'b00, 21'h0, 32'h0, 1, 1'b1, 32'h0);

        // Byte-size write.
`ifdef FLASH_ERASE_EN
        erase_op = 1'b1;
        busy_reads = 2;
        exp_write(1'b1, 20'h00555, 16'h00AA);
        exp_write(1'b1, 20'h002AA, 16'h0055);
        exp_write(1'b1, 20'h00555, 16'h0080);
        exp_write(1'b1, 20'h00555, 16'h00AA);
        exp_write(1'b1, 20'h002AA, 16'h0055);
        exp_write(1'b1, 20'h08000, 16'h0030);
        exp_polls(20'h08000, 3);
        run_xfer("erase", 1'b1, 2'b00, 21'h010000, 32'h0, 76, 1'b0, 32'h0);
        erase_op = 1'b0;
        run_xfer("status_erase", 1'b0, 2'b00, 21'h0, 32'h0, 1, 1'b1, 32'h0);
`else
        base = writes_seen + polls_seen;
        run_xfer("byte_noerase", 1'b1, 2'b00, 21'h010000, 32'h0, 1, 1'b0, 32'h0);
        check("byte_noerase_strobes", writes_seen + polls_seen, base);
        run_xfer("status_byte", 1'b0, 2'b00, 21'h0, 32'h0, 1, 1'b1, 32'h1);
        run_xfer("status_byte_clr", 1'b0, 2'b00, 21'h0, 32'h0, 1, 1'b1, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
